// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg -- shared definitions for the PIO block.
//   Register word addresses on the Avalon-MM slave port, the edge
//   capture mode encoding, and the number of post-reset cycles during
//   which edge capture is held off while the synchronizer fills.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd1;
  localparam logic [2:0] ADDR_EDGECAP = 3'd2;
  localparam logic [2:0] ADDR_OUTSET  = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd4;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Cycles after reset release before an edge may be captured.
  localparam logic [1:0] ARM_CYCLES = 2'd3;

endpackage

// File: rtl/nios_pio_sync_edge.sv
// nios_pio_sync_edge -- input synchronizer and per-bit edge detector.
//   in_port passes through two flops (sync1, sync2); a third flop (sync3)
//   holds the previous synchronized value so edges are found by comparing
//   sync2 against sync3. Edge pulses are masked for ARM_CYCLES cycles
//   after reset release, while the all-zero reset contents of the flops
//   are being replaced by the real input and would otherwise look like
//   edges.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   in_port       asynchronous external inputs (WIDTH)
//   sync_value    synchronized input value (sync2)
//   edges         one-cycle edge pulse per bit of type EDGE_TYPE
module nios_pio_sync_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_value,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] sync1, sync2, sync3;
  logic [WIDTH-1:0] raw_edges;
  logic [1:0]       arm_cnt;
  logic             armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      arm_cnt <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      sync3 <= sync2;
      if (arm_cnt != ARM_CYCLES) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign armed      = (arm_cnt == ARM_CYCLES);
  assign sync_value = sync2;

  always_comb begin
    raw_edges = '0;
    if (EDGE_TYPE == int'(EDGE_RISE))      raw_edges = sync2 & ~sync3;
    else if (EDGE_TYPE == int'(EDGE_FALL)) raw_edges = ~sync2 & sync3;
    else                                   raw_edges = sync2 ^ sync3;
    edges = armed ? raw_edges : '0;
  end

endmodule

// File: rtl/nios_system_pio_ex.sv
// nios_system_pio_ex -- Avalon-MM parallel I/O port.
//   Register map (word address):
//     0 DATA     write: load out_port    read: synchronized in_port
//     1 IRQMASK  write/read interrupt mask
//     2 EDGECAP  read captured edges; write 1 to clear (new edge wins)
//     3 OUTSET   write: out_port |= data  read: out_port
//     4 OUTCLR   write: out_port &= ~data read: out_port
//     5-7        reserved, writes ignored, read 0
//   Bus handshake: a write happens on any cycle with chipselect=1 and
//   write_n=0; a read is requested on any cycle with chipselect=1 and
//   read_n=0 and its data appears on readdata on the following cycle,
//   holding until the next read. There is no wait-state signal; every
//   access completes in one cycle. A read in the same cycle as a write
//   returns the values from before the write.
//   Build option: define NIOS_PIO_EDGE_IRQ_EN to include IRQMASK,
//   EDGECAP and irq. Without it, addresses 1/2 read 0 and irq is 0.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, read_n, writedata Avalon-MM slave inputs
//   readdata                   registered read data (32)
//   in_port                    external inputs (WIDTH)
//   out_port                   output data register (WIDTH)
//   irq                        level interrupt, active-high
module nios_system_pio_ex
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_value, edges;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [WIDTH-1:0] rd_value;
  logic [31:0]      rd_word;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign wdata = writedata[WIDTH-1:0];
  // Bits above WIDTH-1 are intentionally ignored.
  assign unused_wdata = ^writedata;

  nios_pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_value (sync_value),
    .edges      (edges)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   out_port <= wdata;
        ADDR_OUTSET: out_port <= out_port | wdata;
        ADDR_OUTCLR: out_port <= out_port & ~wdata;
        default:     ;
      endcase
    end
  end

`ifdef NIOS_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] cap_clear;

  assign cap_clear = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) irq_mask <= wdata;
      // Clear first, then OR in new edges so a coincident edge survives.
      edge_cap <= (edge_cap & ~cap_clear) | edges;
    end
  end

  // Driven only from registers; bus inputs never reach irq directly.
  assign irq = |(edge_cap & irq_mask);
`else
  logic unused_edges;

  assign irq_mask     = '0;
  assign edge_cap     = '0;
  assign irq          = 1'b0;
  assign unused_edges = ^edges;
`endif

  always_comb begin
    rd_value = '0;
    case (address)
      ADDR_DATA:               rd_value = sync_value;
      ADDR_IRQMASK:            rd_value = irq_mask;
      ADDR_EDGECAP:            rd_value = edge_cap;
      ADDR_OUTSET, ADDR_OUTCLR: rd_value = out_port;
      default:                 rd_value = '0;
    endcase
    rd_word = '0;
    rd_word[WIDTH-1:0] = rd_value;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_word;
  end

endmodule

// File: tb/tb_nios_system_pio_ex.sv
// tb_nios_system_pio_ex -- self-checking bench for nios_system_pio_ex.
//   Reads are checked through an expected queue: the expected word is
//   pushed when the read strobe is driven and popped once readdata is
//   valid. Edge/irq scenarios are selected by NIOS_PIO_EDGE_IRQ_EN.
`timescale 1ns/1ps
module tb_nios_system_pio_ex;

  localparam int         WIDTH       = 8;
  localparam logic [7:0] RESET_VALUE = 8'h5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  nios_system_pio_ex #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .EDGE_TYPE   (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    wait_cycles(1);
    bus_idle();
  endtask

  task automatic do_read(input logic [2:0] a);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    wait_cycles(1);
    bus_idle();
  endtask

  task automatic do_rw(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    read_n     = 1'b0;
    address    = a;
    writedata  = d;
    wait_cycles(1);
    bus_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 8'h00;
    bus_idle();
    wait_cycles(3);
    n_checks++;
    if (out_port !== RESET_VALUE) begin
      n_fail++; $display("FAIL reset_out_port: got %h expected %h", out_port, RESET_VALUE);
    end
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h expected 00000000", readdata);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    reset_n = 1'b1;
    wait_cycles(5);
    for (int a = 1; a <= 2; a++) begin
      exp_q.push_back(32'h0);
      do_read(3'(a));
      exp = exp_q.pop_front();
      n_checks++;
      if (readdata !== exp) begin
        n_fail++; $display("FAIL reset_read_addr%0d: got %h expected %h", a, readdata, exp);
      end
    end
  endtask

  task automatic test_data_write();
    logic [31:0] wr_d[3] = '{32'hA5, 32'h0F, 32'h03};
    logic [2:0]  wr_a[3] = '{3'd0, 3'd4, 3'd3};
    logic [7:0]  exp_o[3] = '{8'hA5, 8'hA0, 8'hA3};
    for (int i = 0; i < 3; i++) begin
      do_write(wr_a[i], wr_d[i]);
      n_checks++;
      if (out_port !== exp_o[i]) begin
        n_fail++; $display("FAIL data_write_%0d: got %h expected %h", i, out_port, exp_o[i]);
      end
    end
    exp_q.push_back(32'h000000A3);
    do_read(3'd3);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL outset_readback: got %h expected %h", readdata, exp);
    end
  endtask

  task automatic test_wide_write();
    do_write(3'd0, 32'hFFFFFF00);
    n_checks++;
    if (out_port !== 8'h00) begin
      n_fail++; $display("FAIL wide_write_low: got %h expected 00", out_port);
    end
    do_write(3'd0, 32'hFFFFFFFF);
    exp_q.push_back(32'h000000FF);
    do_read(3'd4);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL zero_extend: got %h expected %h", readdata, exp);
    end
  endtask

  task automatic test_in_read();
    in_port = 8'h3C;
    wait_cycles(3);
    exp_q.push_back(32'h0000003C);
    do_read(3'd0);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL in_port_read: got %h expected %h", readdata, exp);
    end
    wait_cycles(3);
    n_checks++;
    if (readdata !== 32'h0000003C) begin
      n_fail++; $display("FAIL readdata_hold: got %h expected 0000003c", readdata);
    end
    in_port = 8'h00;
    wait_cycles(4);
  endtask

  task automatic test_reserved();
    for (int a = 5; a <= 7; a++) begin
      do_write(3'(a), 32'h00);
      exp_q.push_back(32'h0);
      do_read(3'(a));
      exp = exp_q.pop_front();
      n_checks++;
      if (readdata !== exp || out_port !== 8'hFF) begin
        n_fail++;
        $display("FAIL reserved_addr%0d: got rd=%h out=%h expected rd=%h out=ff", a, readdata, out_port, exp);
      end
    end
  endtask

  task automatic test_rw_same_cycle();
    do_write(3'd0, 32'h11);
    exp_q.push_back(32'h00000011);
    do_rw(3'd3, 32'h80);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL rw_read_pre_write: got %h expected %h", readdata, exp);
    end
    n_checks++;
    if (out_port !== 8'h91) begin
      n_fail++; $display("FAIL rw_write: got %h expected 91", out_port);
    end
  endtask

`ifdef NIOS_PIO_EDGE_IRQ_EN
  task automatic test_edge_irq();
    int waited;
    do_write(3'd2, 32'hFF);
    do_write(3'd1, 32'h01);
    exp_q.push_back(32'h01);
    do_read(3'd1);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL irqmask_read: got %h expected %h", readdata, exp);
    end
    in_port = 8'h01;
    waited = 0;
    while (irq !== 1'b1 && waited < 4) begin
      wait_cycles(1);
      waited++;
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_rise: got %b expected 1 within 4 cycles", irq);
    end
    exp_q.push_back(32'h01);
    do_read(3'd2);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL edgecap_rise: got %h expected %h", readdata, exp);
    end
    do_write(3'd2, 32'h01);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got %b expected 0", irq);
    end
    in_port = 8'h00;
    wait_cycles(5);
    exp_q.push_back(32'h00);
    do_read(3'd2);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL no_fall_capture: got %h expected %h", readdata, exp);
    end
  endtask

  task automatic test_set_wins();
    do_write(3'd2, 32'hFF);
    in_port = 8'h02;
    // Edge pulse on bit1 is live at the clock edge that samples this write.
    wait_cycles(2);
    do_write(3'd2, 32'h02);
    exp_q.push_back(32'h02);
    do_read(3'd2);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL set_wins: got %h expected %h", readdata, exp);
    end
    do_write(3'd2, 32'h02);
    exp_q.push_back(32'h00);
    do_read(3'd2);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp) begin
      n_fail++; $display("FAIL clear_after: got %h expected %h", readdata, exp);
    end
    in_port = 8'h00;
    wait_cycles(5);
  endtask

  task automatic test_reset_mid();
    do_write(3'd0, 32'hFF);
    do_write(3'd2, 32'hFF);
    do_write(3'd1, 32'h81);
    in_port = 8'h81;
    wait_cycles(5);
    exp_q.push_back(32'h81);
    do_read(3'd2);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp || irq !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_cap: got %h irq=%b expected %h irq=1", readdata, irq, exp);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== RESET_VALUE || irq !== 1'b0 || readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got out=%h irq=%b rd=%h expected out=%h irq=0 rd=0", out_port, irq, readdata, RESET_VALUE);
    end
    in_port = 8'hFF;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(6);
    do_write(3'd1, 32'hFF);
    exp_q.push_back(32'h00);
    do_read(3'd2);
    exp = exp_q.pop_front();
    n_checks++;
    if (readdata !== exp || irq !== 1'b0) begin
      n_fail++; $display("FAIL no_capture_after_reset: got %h irq=%b expected %h irq=0", readdata, irq, exp);
    end
    in_port = 8'h00;
    wait_cycles(5);
  endtask
`else
  task automatic test_no_irq();
    logic [7:0] pat;
    int         bad;
    do_write(3'd1, 32'hFF);
    do_write(3'd2, 32'hFF);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      pat = 8'($urandom_range(0, 255));
      in_port = (i % 2 == 0) ? pat : ~pat;
      wait_cycles(1);
      if (irq !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL irq_tied_low: got %0d cycles with irq=1 expected 0", bad);
    end
    for (int a = 1; a <= 2; a++) begin
      exp_q.push_back(32'h0);
      do_read(3'(a));
      exp = exp_q.pop_front();
      n_checks++;
      if (readdata !== exp) begin
        n_fail++; $display("FAIL no_irq_read_addr%0d: got %h expected %h", a, readdata, exp);
      end
    end
    in_port = 8'h00;
    wait_cycles(4);
  endtask

  task automatic test_reset_mid();
    do_write(3'd0, 32'hFF);
    exp_q.push_back(32'h000000FF);
    do_read(3'd3);
    exp = exp_q.pop_front();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== RESET_VALUE || readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got out=%h rd=%h irq=%b expected out=%h rd=0 irq=0 (pre-reset rd %h)", out_port, readdata, irq, RESET_VALUE, exp);
    end
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(4);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_data_write();
    test_wide_write();
    test_in_read();
    test_reserved();
    test_rw_same_cycle();
`ifdef NIOS_PIO_EDGE_IRQ_EN
    test_edge_irq();
    test_set_wins();
`else
    test_no_irq();
`endif
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
